// File: rtl/param_counter_pkg.sv
// param_counter_pkg: shared types and helpers for the modulo-N up/down counter.
// Build option: define PARAM_COUNTER_SATURATE_EN to make the counter hold at the
// range boundary instead of wrapping (default: modulo wrap).
package param_counter_pkg;

  localparam logic [1:0] CNT_IDLE_ENC = 2'd0;
  localparam logic [1:0] CNT_RUN_ENC  = 2'd1;
  localparam logic [1:0] CNT_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    CNT_IDLE = CNT_IDLE_ENC,
    CNT_RUN  = CNT_RUN_ENC,
    CNT_DONE = CNT_DONE_ENC
  } cnt_state_t;

`ifdef PARAM_COUNTER_SATURATE_EN
  localparam logic SATURATE = 1'b1;
`else
  localparam logic SATURATE = 1'b0;
`endif

  // True when a step in the given direction would leave the range 0..modulus-1.
  function automatic logic at_boundary(input logic [31:0] cur, input logic up,
                                       input logic [31:0] modulus);
    return up ? (cur == modulus - 32'd1) : (cur == 32'd0);
  endfunction

  // Count value after one step: wraps or holds at the boundary.
  function automatic logic [31:0] next_count(input logic [31:0] cur, input logic up,
                                             input logic [31:0] modulus, input logic sat);
    if (at_boundary(cur, up, modulus)) begin
      if (sat) return cur;
      return up ? 32'd0 : modulus - 32'd1;
    end
    return up ? cur + 32'd1 : cur - 32'd1;
  endfunction

endpackage

// File: rtl/param_counter_prescaler.sv
// tick_prescaler: emits a one-cycle tick on every PRESCALE-th enabled cycle.
// clear_i restarts the phase and suppresses the tick for that cycle.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  assign tick_o = en_i & ~clear_i & (cnt_q == LAST);

  // Phase counter over enabled cycles; returns to 0 after the last phase.
  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/param_counter.sv
// param_counter: parametrised modulo-N up/down counter with parallel load,
// prescaled enable, one-shot mode, terminal-count pulse and sticky overflow.
// Build option: PARAM_COUNTER_SATURATE_EN selects hold-at-boundary instead of wrap.
module param_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             busy
);
  import param_counter_pkg::*;

  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             hit;
  logic             load_too_big;

  // Stop also restarts the prescaler so a later start begins on a fresh phase.
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en & (state_q == CNT_RUN)),
    .clear_i (load | stop),
    .tick_o  (tick)
  );

  assign load_too_big = 32'(load_val) >= 32'(MODULUS);

  // Next-state: load beats step, a boundary step raises tc/ovf, FSM follows.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    hit     = 1'b0;
    if (load) begin
      count_d = load_too_big ? MOD_MAX : load_val;
    end else if (tick) begin
      hit     = at_boundary(32'(count_q), up_dn, 32'(MODULUS));
      count_d = WIDTH'(next_count(32'(count_q), up_dn, 32'(MODULUS), SATURATE));
    end
    tc_d  = hit;
    ovf_d = hit | (ovf_q & ~clr_ovf);
    case (state_q)
      CNT_IDLE: if (start && !stop) state_d = CNT_RUN;
      CNT_RUN: begin
        if (stop)                state_d = CNT_IDLE;
        else if (hit && oneshot) state_d = CNT_DONE;
      end
      CNT_DONE: if (start && !stop) state_d = CNT_RUN;
      default:  state_d = CNT_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CNT_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == CNT_RUN);

endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: directed and randomized checks of param_counter (MODULUS=10)
// at PRESCALE=1 and PRESCALE=3 against a behavioural model of the counter rules.
module tb_param_counter;

  localparam int W = 4;
  localparam int M = 10;
`ifdef PARAM_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, en, up_dn, start, stop, oneshot, load, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] count1, count3;
  logic         tc1, ovf1, busy1, tc3, ovf3, busy3;

  param_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
    .oneshot(oneshot), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count1), .tc(tc1), .ovf(ovf1), .busy(busy1)
  );

  param_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(3)) dut_p3 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .start(start), .stop(stop),
    .oneshot(oneshot), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count3), .tc(tc3), .ovf(ovf3), .busy(busy3)
  );

  // Model: mode 0 = idle, 1 = running, 2 = halted after a one-shot boundary.
  typedef struct {
    int cnt;
    int mode;
    int phase;
    bit tc;
    bit ovf;
  } model_t;

  model_t m1, m3;
  int     tests_run    = 0;
  int     tests_failed = 0;

  function automatic model_t model_step(model_t m, int p);
    model_t n;
    bit     tick;
    bit     hit;
    int     tgt;
    n    = m;
    tick = 1'b0;
    hit  = 1'b0;
    if (reset) begin
      n.cnt = 0; n.mode = 0; n.phase = 0; n.tc = 1'b0; n.ovf = 1'b0;
      return n;
    end
    if (stop || load) begin
      n.phase = 0;
    end else if (m.mode == 1 && en) begin
      n.phase = (m.phase + 1) % p;
      tick    = (n.phase == 0);
    end
    if (load) begin
      n.cnt = (int'(load_val) >= M) ? M - 1 : int'(load_val);
    end else if (tick) begin
      tgt = up_dn ? m.cnt + 1 : m.cnt - 1;
      hit = (tgt < 0) || (tgt >= M);
      if (!hit)     n.cnt = tgt;
      else if (SAT) n.cnt = m.cnt;
      else          n.cnt = (tgt + M) % M;
    end
    n.tc  = hit;
    n.ovf = hit || (m.ovf && !clr_ovf);
    if (m.mode == 1) begin
      if (stop)                n.mode = 0;
      else if (hit && oneshot) n.mode = 2;
    end else if (start && !stop) begin
      n.mode = 1;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string phase);
    check({phase, " count p1"}, 32'(count1), m1.cnt);
    check({phase, " tc p1"},    32'(tc1),    32'(m1.tc));
    check({phase, " ovf p1"},   32'(ovf1),   32'(m1.ovf));
    check({phase, " busy p1"},  32'(busy1),  32'(m1.mode == 1));
    check({phase, " count p3"}, 32'(count3), m3.cnt);
    check({phase, " tc p3"},    32'(tc3),    32'(m3.tc));
    check({phase, " ovf p3"},   32'(ovf3),   32'(m3.ovf));
    check({phase, " busy p3"},  32'(busy3),  32'(m3.mode == 1));
  endtask

  // One clock: model advances on the inputs seen at the edge, outputs checked 1ns later.
  task automatic cycle(input string phase);
    @(posedge clk);
    m1 = model_step(m1, 1);
    m3 = model_step(m3, 3);
    #1;
    compare_all(phase);
  endtask

  task automatic quiet_inputs();
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; start = 1'b0; stop = 1'b0;
    oneshot = 1'b0; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
  endtask

  initial begin
    quiet_inputs();
    m1 = '{default: 0};
    m3 = '{default: 0};

    // 1: reset, start, count up 12 enabled cycles through the wrap
    reset = 1'b1; cycle("reset");
    reset = 1'b0;
    check("reset count const", 32'(count1), 0);
    check("reset busy const",  32'(busy1),  0);
    start = 1'b1; cycle("start");
    start = 1'b0; en = 1'b1; up_dn = 1'b1;
    repeat (12) cycle("t1 up");
    check("t1 final count", 32'(count1), SAT ? 9 : 2);
    check("t1 ovf sticky",  32'(ovf1),   1);

    // 2: count down from 0, then clear ovf; then set beats clear
    load = 1'b1; load_val = 4'd0; cycle("t2 load0");
    load = 1'b0; up_dn = 1'b0; cycle("t2 down wrap");
    clr_ovf = 1'b1; cycle("t2 clr");
    clr_ovf = 1'b0; cycle("t2 after clr");
    load = 1'b1; load_val = 4'd0; cycle("t2 load0 again");
    load = 1'b0; clr_ovf = 1'b1; cycle("t2 set wins");
    clr_ovf = 1'b0;

    // 3: one-shot from 7 counting up, halt, then resume
    stop = 1'b1; cycle("t3 stop");
    stop = 1'b0; oneshot = 1'b1; up_dn = 1'b1;
    load = 1'b1; load_val = 4'd7; cycle("t3 load7");
    load = 1'b0; start = 1'b1; cycle("t3 start");
    start = 1'b0;
    repeat (6) cycle("t3 oneshot");
    start = 1'b1; cycle("t3 resume");
    start = 1'b0; oneshot = 1'b0;
    repeat (3) cycle("t3 run");

    // 4: clamped load, load over step, start+stop
    load = 1'b1; load_val = 4'd13; cycle("t4 load13");
    load_val = 4'd15; cycle("t4 load15");
    load_val = 4'd4; cycle("t4 load vs tick");
    load = 1'b0;
    start = 1'b1; stop = 1'b1; cycle("t4 start+stop run");
    cycle("t4 start+stop idle");
    start = 1'b0; stop = 1'b0;
    repeat (2) cycle("t4 idle hold");

    // 5: prescaled stepping and en freeze
    load = 1'b1; load_val = 4'd0; cycle("t5 load0");
    load = 1'b0; start = 1'b1; cycle("t5 start");
    start = 1'b0;
    repeat (9) cycle("t5 en");
    en = 1'b0;
    repeat (5) cycle("t5 frozen");
    en = 1'b1;
    repeat (4) cycle("t5 resume");

    // 6: boundary from 8 upward, then reset mid-run with other inputs busy
    load = 1'b1; load_val = 4'd8; cycle("t6 load8");
    load = 1'b0;
    repeat (3) cycle("t6 boundary");
    reset = 1'b1; start = 1'b1; load = 1'b1; load_val = 4'd5; clr_ovf = 1'b0;
    cycle("t6 reset");
    check("t6 reset count const", 32'(count1), 0);
    check("t6 reset ovf const",   32'(ovf1),   0);
    quiet_inputs();
    cycle("t6 after reset");

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom % 64) == 0;
      en       = ($urandom % 4) != 0;
      up_dn    = ($urandom % 2) == 0;
      start    = ($urandom % 8) == 0;
      stop     = ($urandom % 20) == 0;
      oneshot  = ($urandom % 4) == 0;
      load     = ($urandom % 12) == 0;
      load_val = W'($urandom % 16);
      clr_ovf  = ($urandom % 10) == 0;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
